axis_pkt_fifo: RTL and testbench
================================

AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 9, log2 of buffer capacity in 64-bit beats (capacity = 2^DEPTH_LOG2).
REQ-002 Port clk  input  1  sole clock; all logic rising-edge.
REQ-003 Port rst  input  1  reset; synchronous, active-low.
REQ-004 Port s_axis_rx_tvalid  input  1  upstream beat valid.
REQ-005 Port s_axis_rx_tdata  input  64  upstream data.
REQ-006 Port s_axis_rx_tkeep  input  8  upstream byte enables.
REQ-007 Port s_axis_rx_tlast  input  1  upstream end of frame.
REQ-008 Port s_axis_rx_tuser  input  1  upstream error flag.
REQ-009 Port s_axis_rx_tready  output  1  upstream ready.
REQ-010 Port m_axis_tx_tready  input  1  downstream ready.
REQ-011 Port m_axis_tx_tvalid / m_axis_tx_tdata / m_axis_tx_tkeep / m_axis_tx_tlast / m_axis_tx_tuser  output  1/64/8/1/1  downstream AXIS beat.
REQ-012 Port drop_cnt  output  32  dropped-frame count; present only under REQ-034.

Function
REQ-013 Block SHALL be a store-and-forward frame FIFO; storage word = {tlast, tkeep, tdata}, 73 bits; tuser not stored.
REQ-014 Write handshake = s_axis_rx_tvalid && s_axis_rx_tready; s_axis_rx_tready SHALL be 1 every cycle outside reset (no upstream backpressure; overflow handled by drop).
REQ-015 Pointers wr_ptr (speculative), wr_commit, rd_ptr SHALL be DEPTH_LOG2+1 bits with wrap bit; full = wr_ptr and rd_ptr differ only in MSB.
REQ-016 Write FSM states: IDLE, WRITE, DROP; IDLE->WRITE on first accepted beat without tlast; WRITE->IDLE on accepted tlast; any state->DROP on accepted non-last beat with tuser=1 or arriving while full; DROP->IDLE on accepted tlast.
REQ-017 Accepted beat in IDLE/WRITE, not full, SHALL be written at wr_ptr and wr_ptr incremented.
REQ-018 Accepted tlast beat, frame clean (no tuser on any beat, no overflow, including the tlast beat itself), SHALL set wr_commit <= wr_ptr+1 in the same edge.
REQ-019 Accepted tlast beat of dropped frame SHALL restore wr_ptr <= wr_commit; no beat of that frame reaches output.
REQ-020 Frames longer than capacity SHALL always be dropped; single-beat frames (tvalid+tlast same cycle) SHALL be supported.
REQ-021 Read side SHALL only read words in [rd_ptr, wr_commit); rollback or commit SHALL not disturb a frame being read.
REQ-022 Output SHALL be registered; m_axis_tx_tvalid asserts no later than 3 clk after the commit edge.
REQ-023 With m_axis_tx_tready held 1, output SHALL sustain 1 beat/clk, including back-to-back frames with no idle cycle.
REQ-024 While m_axis_tx_tvalid && !m_axis_tx_tready, all m_axis_tx_* SHALL hold stable.
REQ-025 m_axis_tx_tuser SHALL be constant 0.
REQ-026 Frame order SHALL be preserved; tkeep passed unmodified.
REQ-027 Commit and read in same cycle, and read of last stored word while new frame writes, SHALL both be legal with no lost or duplicated beat.

Reset
REQ-028 rst=0 at a clk edge SHALL clear wr_ptr, wr_commit, rd_ptr, write FSM to IDLE, output register invalid.
REQ-029 During reset: s_axis_rx_tready=0, m_axis_tx_tvalid=0, m_axis_tx_tdata=0, m_axis_tx_tkeep=0, m_axis_tx_tlast=0, m_axis_tx_tuser=0, drop_cnt=0.
REQ-030 s_axis_rx_tready SHALL be 1 in the first cycle after rst returns high.
REQ-031 Reset mid-frame SHALL discard all stored and partial frames; truncated downstream frame is permitted.
REQ-032 Memory array SHALL not require reset.

Configuration
REQ-033 Macro AXIS_PKT_FIFO_DROP_CNT_EN selects drop counting.
REQ-034 Defined: drop_cnt port exists; increments by 1 at each dropped frame's tlast edge; saturates at 0xFFFFFFFF.
REQ-035 Undefined: no drop_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-036 Single 8-beat frame, tkeep=0xFF except last 0x0F, tready=1 -> identical 8 beats out, tvalid within 3 clk of commit, tuser=0.
REQ-037 Frame with tuser=1 on tlast beat followed by clean 2-beat frame -> only 2-beat frame out; drop_cnt=1 (macro on).
REQ-038 DEPTH_LOG2=4, 20-beat frame then 4-beat frame -> 20-beat dropped, 4-beat out intact; wr_ptr equals wr_commit after drop.
REQ-039 Three back-to-back frames, m_axis_tx_tready toggling 1010... -> all beats in order, outputs stable while stalled.
REQ-040 rst low for 1 clk during output of frame 2 of 3 -> all outputs 0, tready=0 that cycle; tready=1 next cycle; subsequent new frame passes correctly.
REQ-041 2^DEPTH_LOG2-beat frame with downstream tready=0 -> stored and output complete; next frame dropped until space frees.

Source files
------------

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: store-and-forward AXI-Stream frame FIFO, 64-bit beats.
// Frames are written speculatively and become visible to the reader only
// once their last beat arrives clean; errored or overflowing frames are
// rolled back. Optional dropped-frame counter: AXIS_PKT_FIFO_DROP_CNT_EN.
module axis_pkt_fifo #(
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_rx_tvalid,
  input  logic [63:0] s_axis_rx_tdata,
  input  logic [7:0]  s_axis_rx_tkeep,
  input  logic        s_axis_rx_tlast,
  input  logic        s_axis_rx_tuser,
  output logic        s_axis_rx_tready,
  input  logic        m_axis_tx_tready,
  output logic        m_axis_tx_tvalid,
  output logic [63:0] m_axis_tx_tdata,
  output logic [7:0]  m_axis_tx_tkeep,
  output logic        m_axis_tx_tlast,
  output logic        m_axis_tx_tuser
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
  ,
  output logic [31:0] drop_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [72:0]         mem [DEPTH];
  logic [1:0]          state_q, state_d;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] wr_commit_q, wr_commit_d;
  logic [DEPTH_LOG2:0] rd_ptr_q;
  logic [DEPTH_LOG2:0] wr_ptr_inc;
  logic                wr_acc, full, bad_beat, wr_en;
  logic                rd_avail, out_load;
  logic                out_valid_q;
  logic [72:0]         out_word_q;

  // Never backpressure upstream; overflow is handled by dropping the frame.
  assign s_axis_rx_tready = rst;
  assign wr_acc     = s_axis_rx_tvalid & s_axis_rx_tready;
  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
  assign full       = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                      (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign bad_beat   = s_axis_rx_tuser | full;

  // Reader only ever sees words below the commit pointer.
  assign rd_avail = (rd_ptr_q != wr_commit_q);
  assign out_load = ~out_valid_q | m_axis_tx_tready;

  // Write-side frame state machine: speculative write, commit or rollback.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wr_en       = 1'b0;
    if (wr_acc) begin
      if (state_q == ST_DROP) begin
        if (s_axis_rx_tlast) begin
          wr_ptr_d = wr_commit_q;
          state_d  = ST_IDLE;
        end
      end else begin
        wr_en = ~full;
        if (bad_beat) begin
          if (s_axis_rx_tlast) begin
            wr_ptr_d = wr_commit_q;
            state_d  = ST_IDLE;
          end else begin
            wr_ptr_d = full ? wr_ptr_q : wr_ptr_inc;
            state_d  = ST_DROP;
          end
        end else begin
          wr_ptr_d = wr_ptr_inc;
          if (s_axis_rx_tlast) begin
            wr_commit_d = wr_ptr_inc;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
    end
  end

  // Frame storage; contents are don't-care until committed, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_axis_rx_tlast, s_axis_rx_tkeep, s_axis_rx_tdata};
    end
  end

  // Pointer, state and registered-output updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      if (out_load) begin
        out_valid_q <= rd_avail;
        if (rd_avail) begin
          out_word_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
          rd_ptr_q   <= rd_ptr_q + PTR_ONE;
        end
      end
    end
  end

  assign m_axis_tx_tvalid = rst & out_valid_q;
  assign m_axis_tx_tdata  = rst ? out_word_q[63:0]  : '0;
  assign m_axis_tx_tkeep  = rst ? out_word_q[71:64] : '0;
  assign m_axis_tx_tlast  = rst & out_word_q[72];
  assign m_axis_tx_tuser  = 1'b0;

`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
  logic [31:0] drop_cnt_q;
  logic        drop_done;

  assign drop_done = wr_acc & s_axis_rx_tlast & ((state_q == ST_DROP) | bad_beat);

  // Saturating count of frames discarded at their last beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (drop_done && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign drop_cnt = rst ? drop_cnt_q : '0;
`endif

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo (DEPTH_LOG2=4). Expected output is
// a frame-level model: a frame appears intact iff it is error-free and fits.
module tb_axis_pkt_fifo;

  localparam int unsigned DL2 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        s_tready;
  logic        m_tready = 1'b0;
  logic        m_tvalid;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tuser;
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
  logic [31:0] drop_cnt;
`endif

  axis_pkt_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_rx_tvalid (s_tvalid),
    .s_axis_rx_tdata  (s_tdata),
    .s_axis_rx_tkeep  (s_tkeep),
    .s_axis_rx_tlast  (s_tlast),
    .s_axis_rx_tuser  (s_tuser),
    .s_axis_rx_tready (s_tready),
    .m_axis_tx_tready (m_tready),
    .m_axis_tx_tvalid (m_tvalid),
    .m_axis_tx_tdata  (m_tdata),
    .m_axis_tx_tkeep  (m_tkeep),
    .m_axis_tx_tlast  (m_tlast),
    .m_axis_tx_tuser  (m_tuser)
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
    ,
    .drop_cnt         (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        user;
    logic [72:0] w;
  } tx_t;

  tx_t         tx_q[$];
  logic [72:0] exp_q[$];
  logic [72:0] got_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int exp_drops = 0;
  int stall_viol, tuser_viol, gaps, first_valid_cyc, commit_cyc;
  bit timed_out;

  // Queue a frame for sending; kept frames are also appended to the model.
  task automatic make_frame(input int len, input int bad, input bit rand_keep,
                            input logic [7:0] last_keep, input bit kept);
    for (int i = 0; i < len; i++) begin
      tx_t t;
      logic [7:0] k;
      k = rand_keep ? 8'($urandom) : ((i == len - 1) ? last_keep : 8'hFF);
      t.w = {(i == len - 1), k, $urandom, $urandom};
      t.user = (i == bad);
      tx_q.push_back(t);
      if (kept) exp_q.push_back(t.w);
    end
  endtask

  task automatic drive_all(input bit gaps_en);
    while (tx_q.size() > 0) begin
      tx_t t = tx_q.pop_front();
      if (gaps_en && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        s_tvalid = 1'b0;
      end
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      s_tdata  = t.w[63:0];
      s_tkeep  = t.w[71:64];
      s_tlast  = t.w[72];
      s_tuser  = t.user;
      if (t.w[72]) commit_cyc = cyc + 1;
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
  endtask

  // Downstream sink: records accepted beats and protocol observations.
  task automatic collect(input int n, input int mode, input int budget);
    int extra = 0;
    bit stalled = 1'b0;
    logic [74:0] prev = '0;
    logic [74:0] cur;
    got_q.delete();
    stall_viol = 0; tuser_viol = 0; gaps = 0; first_valid_cyc = -1; timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (got_q.size() >= n) m_tready = 1'b1;
      else if (mode == 0)    m_tready = 1'b1;
      else if (mode == 1)    m_tready = (c % 2 == 0);
      else                   m_tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cur = {m_tvalid, m_tlast, m_tkeep, m_tdata, m_tuser};
      if (stalled && cur !== prev) stall_viol++;
      stalled = m_tvalid && !m_tready;
      prev = cur;
      if (m_tvalid && m_tuser !== 1'b0) tuser_viol++;
      if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_tready && !m_tvalid && got_q.size() > 0 && got_q.size() < n) gaps++;
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tkeep, m_tdata});
      if (got_q.size() >= n) begin
        extra++;
        if (extra > 20) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser} !== '0)
      $display("FAIL reset_outputs got %h required 0", {s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser});
    else n_pass++;
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 32'd0) $display("FAIL reset_drop_cnt got %0d required 0", drop_cnt);
    else n_pass++;
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_tready !== 1'b1) $display("FAIL reset_release_tready got %b required 1", s_tready);
    else n_pass++;
    n_checks++;
    if (m_tvalid !== 1'b0) $display("FAIL reset_release_tvalid got %b required 0", m_tvalid);
    else n_pass++;
  endtask

  task automatic test_single;
    make_frame(8, -1, 1'b0, 8'h0F, 1'b1);
    fork
      drive_all(1'b0);
      collect(8, 0, 200);
    join
    n_checks++;
    if (timed_out || got_q.size() != 8) $display("FAIL single_count got %0d required 8 (timeout %b)", got_q.size(), timed_out);
    else n_pass++;
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL single_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (first_valid_cyc < 0 || first_valid_cyc - commit_cyc > 3)
      $display("FAIL single_latency got %0d required <=3", first_valid_cyc - commit_cyc);
    else n_pass++;
    n_checks++;
    if (tuser_viol !== 0) $display("FAIL single_tuser got %0d beats with tuser required 0", tuser_viol);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_tuser_drop;
    make_frame(5, 4, 1'b1, 8'h00, 1'b0);
    make_frame(2, -1, 1'b1, 8'h00, 1'b1);
    make_frame(3, 1, 1'b1, 8'h00, 1'b0);
    make_frame(1, 0, 1'b1, 8'h00, 1'b0);
    make_frame(1, -1, 1'b1, 8'h00, 1'b1);
    exp_drops += 3;
    fork
      drive_all(1'b0);
      collect(3, 0, 200);
    join
    n_checks++;
    if (timed_out || got_q.size() != 3) $display("FAIL tuser_count got %0d required 3", got_q.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL tuser_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 32'(exp_drops)) $display("FAIL tuser_drop_cnt got %0d required %0d", drop_cnt, exp_drops);
    else n_pass++;
`endif
    exp_q.delete();
  endtask

  task automatic test_oversize;
    make_frame(20, -1, 1'b1, 8'h00, 1'b0);
    make_frame(4, -1, 1'b1, 8'h00, 1'b1);
    exp_drops++;
    fork
      drive_all(1'b0);
      collect(4, 0, 300);
    join
    n_checks++;
    if (timed_out || got_q.size() != 4) $display("FAIL oversize_count got %0d required 4", got_q.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL oversize_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
    // A full-capacity frame only fits if the rollback freed every slot.
    make_frame(16, -1, 1'b1, 8'h00, 1'b1);
    fork
      drive_all(1'b0);
      collect(16, 0, 300);
    join
    n_checks++;
    if (timed_out || got_q.size() != 16) $display("FAIL oversize_refill_count got %0d required 16", got_q.size());
    else n_pass++;
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL oversize_refill_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 32'(exp_drops)) $display("FAIL oversize_drop_cnt got %0d required %0d", drop_cnt, exp_drops);
    else n_pass++;
`endif
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    m_tready = 1'b0;
    make_frame(3, -1, 1'b1, 8'h00, 1'b1);
    make_frame(5, -1, 1'b1, 8'h00, 1'b1);
    make_frame(4, -1, 1'b1, 8'h00, 1'b1);
    drive_all(1'b0);
    collect(12, 0, 200);
    n_checks++;
    if (timed_out || got_q.size() != 12) $display("FAIL b2b_count got %0d required 12", got_q.size());
    else n_pass++;
    n_checks++;
    if (gaps !== 0) $display("FAIL b2b_rate got %0d idle cycles required 0", gaps);
    else n_pass++;
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL b2b_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
    make_frame(3, -1, 1'b1, 8'h00, 1'b1);
    make_frame(5, -1, 1'b1, 8'h00, 1'b1);
    make_frame(4, -1, 1'b1, 8'h00, 1'b1);
    fork
      drive_all(1'b0);
      collect(12, 1, 400);
    join
    n_checks++;
    if (timed_out || got_q.size() != 12) $display("FAIL toggle_count got %0d required 12", got_q.size());
    else n_pass++;
    n_checks++;
    if (stall_viol !== 0) $display("FAIL toggle_stable got %0d changes while stalled required 0", stall_viol);
    else n_pass++;
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL toggle_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
  endtask

  task automatic test_full;
    m_tready = 1'b0;
    make_frame(16, -1, 1'b1, 8'h00, 1'b1);
    make_frame(4, -1, 1'b1, 8'h00, 1'b0);
    exp_drops++;
    drive_all(1'b0);
    repeat (4) @(posedge clk);
    collect(16, 1, 300);
    n_checks++;
    if (timed_out || got_q.size() != 16) $display("FAIL full_count got %0d required 16", got_q.size());
    else n_pass++;
    n_checks++;
    if (stall_viol !== 0) $display("FAIL full_stable got %0d changes while stalled required 0", stall_viol);
    else n_pass++;
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL full_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 32'(exp_drops)) $display("FAIL full_drop_cnt got %0d required %0d", drop_cnt, exp_drops);
    else n_pass++;
`endif
    exp_q.delete();
    make_frame(3, -1, 1'b1, 8'h00, 1'b1);
    fork
      drive_all(1'b0);
      collect(3, 0, 200);
    join
    n_checks++;
    if (timed_out || got_q.size() != 3) $display("FAIL full_after_count got %0d required 3", got_q.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL full_after_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    m_tready = 1'b0;
    make_frame(5, -1, 1'b1, 8'h00, 1'b1);
    make_frame(5, -1, 1'b1, 8'h00, 1'b1);
    make_frame(5, -1, 1'b1, 8'h00, 1'b1);
    drive_all(1'b0);
    got_q.delete();
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      m_tready = 1'b1;
      @(negedge clk);
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tkeep, m_tdata});
      if (got_q.size() >= 7) break;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser} !== '0)
      $display("FAIL midrst_outputs got %h required 0", {s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser});
    else n_pass++;
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 32'd0) $display("FAIL midrst_drop_cnt got %0d required 0", drop_cnt);
    else n_pass++;
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    exp_drops = 0;
    @(negedge clk);
    n_checks++;
    if (s_tready !== 1'b1) $display("FAIL midrst_tready got %b required 1", s_tready);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 7) $display("FAIL midrst_prefix_count got %0d required 7", got_q.size());
    else n_pass++;
    for (int i = 0; i < 7 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL midrst_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_tvalid) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL midrst_discard got %0d valid beats required 0", seen);
    else n_pass++;
    make_frame(4, -1, 1'b1, 8'h00, 1'b1);
    fork
      drive_all(1'b0);
      collect(4, 0, 200);
    join
    n_checks++;
    if (timed_out || got_q.size() != 4) $display("FAIL midrst_new_count got %0d required 4", got_q.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL midrst_new_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
  endtask

  task automatic test_random;
    for (int b = 0; b < 10; b++) begin
      int total = 0;
      int nexp;
      for (int f = 0; f < 16; f++) begin
        int len = $urandom_range(1, 8);
        int bad = -1;
        if (total + len > 16) break;
        if ($urandom_range(0, 3) == 0) bad = $urandom_range(0, len - 1);
        make_frame(len, bad, 1'b1, 8'h00, bad < 0);
        if (bad >= 0) exp_drops++;
        total += len;
      end
      nexp = exp_q.size();
      fork
        drive_all(1'b1);
        collect(nexp, 2, 400);
      join
      n_checks++;
      if (timed_out || got_q.size() != nexp) $display("FAIL rand%0d_count got %0d required %0d", b, got_q.size(), nexp);
      else n_pass++;
      for (int i = 0; i < nexp && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rand%0d_beat%0d got %h required %h", b, i, got_q[i], exp_q[i]);
        else n_pass++;
      end
      n_checks++;
      if (stall_viol !== 0 || tuser_viol !== 0)
        $display("FAIL rand%0d_protocol got stall %0d tuser %0d required 0 0", b, stall_viol, tuser_viol);
      else n_pass++;
      exp_q.delete();
    end
`ifdef AXIS_PKT_FIFO_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 32'(exp_drops)) $display("FAIL rand_drop_cnt got %0d required %0d", drop_cnt, exp_drops);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_tuser_drop();
    test_oversize();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
